busn2m_pack: RTL and testbench
==============================

BUSN2M_PACK -- requirements
Module: busn2m_pack

Interface
REQ-001 Parameter IN_WIDTH, default 96, SHALL be the narrow input word width in bits.
REQ-002 Parameter OUT_WIDTH, default 512, SHALL be the wide output word width in bits.
REQ-003 Parameter COM_MUL, default 1536, SHALL be the staging-register width; IN_WIDTH and OUT_WIDTH SHALL each divide it exactly.
REQ-004 Parameter IN_COUNT, default COM_MUL/IN_WIDTH, SHALL be the number of input words per group.
REQ-005 Parameter OUT_COUNT, default COM_MUL/OUT_WIDTH, SHALL be the number of output words per group.
REQ-006 Parameter M, default 60, SHALL be the number of output words per blob.
REQ-007 The module SHALL have one clock; reset SHALL be synchronous and active-high.
REQ-008 The ports SHALL be as follows (port, direction, width, meaning):
- clk, in, 1, clock.
- rst, in, 1, synchronous active-high reset.
- blob_din, in, IN_WIDTH, narrow input word.
- blob_din_rdy, out, 1, module can accept input.
- blob_din_en, in, 1, input transfer strobe; asserted only while blob_din_rdy=1.
- blob_din_eop, in, 1, last input word of the blob; qualified by blob_din_en.
- blob_dout, out, OUT_WIDTH, wide output word.
- blob_dout_rdy, in, 1, downstream ready.
- blob_dout_en, out, 1, output transfer strobe.
- blob_dout_eop, out, 1, last output word of the blob; qualified by blob_dout_en.

Function
REQ-009 The block SHALL use a state machine with states FILL, PAD and DRAIN; the reset state SHALL be FILL.
REQ-010 In FILL, blob_din_rdy SHALL be 1; in PAD and DRAIN, blob_din_rdy SHALL be 0.
REQ-011 Each accepted word SHALL be shifted into the COM_MUL staging register from the MSB end, i.e. {blob_din, stage[COM_MUL-1:IN_WIDTH]}, so that the first word of a group ends in bits [IN_WIDTH-1:0].
REQ-012 din_cnt (0..IN_COUNT-1) SHALL increment on every accepted word and on every pad cycle, and SHALL wrap to 0 after IN_COUNT-1.
REQ-013 An accept with din_cnt=IN_COUNT-1 SHALL move FILL->DRAIN, with or without eop.
REQ-014 An accept with eop and din_cnt<IN_COUNT-1 SHALL move FILL->PAD.
REQ-015 In PAD, the block SHALL shift in one all-zero word per cycle; the cycle with din_cnt=IN_COUNT-1 SHALL move PAD->DRAIN. A blob with k words in its last group (0<k<IN_COUNT) SHALL therefore take IN_COUNT-k pad cycles.
REQ-016 blob_dout SHALL equal stage[OUT_WIDTH-1:0] at all times.
REQ-017 blob_dout_en SHALL equal (state==DRAIN) & blob_dout_rdy.
REQ-018 On each blob_dout_en, stage SHALL shift right by OUT_WIDTH.
REQ-019 In DRAIN, blob_dout and stage SHALL hold while blob_dout_rdy=0.
REQ-020 The first output of a group SHALL be available in the cycle after the completing accept or the last pad cycle (latency 1).
REQ-021 dout_cnt (0..OUT_COUNT-1) SHALL count output words within a group.
REQ-022 dout_total (0..M-1) SHALL count output words within a blob.
REQ-023 blob_dout_eop SHALL equal blob_dout_en & (dout_total==M-1).
REQ-024 DRAIN->FILL SHALL occur on a blob_dout_en with dout_cnt=OUT_COUNT-1 or dout_total=M-1.
REQ-025 On that DRAIN->FILL transition, dout_cnt SHALL clear, and the remaining group data SHALL be discarded (truncation of pad words).
REQ-026 dout_total SHALL clear after the eop word.
REQ-027 din_cnt SHALL clear whenever eop processing completes, so the next blob starts aligned at slot 0.
REQ-028 A new blob SHALL be accepted in the cycle after DRAIN->FILL, with no idle gap beyond that.
REQ-029 If input eop arrives before M outputs have been produced, dout_total SHALL NOT be forced and SHALL continue into the next blob.
REQ-030 If dout_total reaches M-1 before input eop arrives, the eop SHALL still be emitted and subsequent words SHALL start a new count; no error flag is required.

Reset
REQ-031 rst SHALL be synchronous and active-high, with priority over all other activity, including mid-DRAIN and mid-PAD.
REQ-032 On reset, state SHALL be FILL, and stage, din_cnt, dout_cnt and dout_total SHALL be 0.
REQ-033 On reset, the outputs SHALL be blob_din_rdy=1, blob_dout=0, blob_dout_en=0 and blob_dout_eop=0.

Verification (config IN_WIDTH=8, OUT_WIDTH=16, COM_MUL=32, M=4 unless noted)
REQ-034 Full blob: feed bytes 0x01..0x08 with eop on 0x08 and dout_rdy=1 -> outputs 0x0201, 0x0403, 0x0605, 0x0807, with eop only on 0x0807; blob_din_rdy low for exactly 2 cycles after 0x04 and after 0x08.
REQ-035 Partial with pad and truncation (M=3): feed 0x11..0x16 with eop on 0x16 -> 2 PAD cycles, then outputs 0x1211, 0x1413, 0x1615 with eop on 0x1615; the zero word is never emitted; blob_din_rdy returns to 1 the cycle after 0x1615.
REQ-036 Backpressure: hold dout_rdy=0 for 5 cycles in DRAIN -> blob_dout stable at 0x0201, blob_dout_en=0, blob_din_rdy=0; on release, the sequence resumes unchanged.
REQ-037 Reset mid-DRAIN: assert rst after the first output -> the next cycle shows state FILL, blob_din_rdy=1, blob_dout=0; a fresh blob 0x01..0x08 reproduces the REQ-034 outputs exactly.
REQ-038 Back-to-back blobs: two blobs of 0x01..0x08 with eop on each, dout_rdy=1 -> 8 outputs total; eop on the 4th and 8th; the second blob's first word is accepted the cycle after the first eop output.

Source files
------------

// File: rtl/busn2m_pack.sv
// Narrow-to-wide blob packer: IN_WIDTH words fill a COM_MUL staging register
// that is then drained as OUT_WIDTH words; short final groups are zero-padded.
module busn2m_pack #(
    parameter int IN_WIDTH  = 96,
    parameter int OUT_WIDTH = 512,
    parameter int COM_MUL   = 1536,
    parameter int IN_COUNT  = COM_MUL / IN_WIDTH,
    parameter int OUT_COUNT = COM_MUL / OUT_WIDTH,
    parameter int M         = 60
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IN_WIDTH-1:0]  blob_din,
    output logic                 blob_din_rdy,
    input  logic                 blob_din_en,
    input  logic                 blob_din_eop,
    output logic [OUT_WIDTH-1:0] blob_dout,
    input  logic                 blob_dout_rdy,
    output logic                 blob_dout_en,
    output logic                 blob_dout_eop
);

    localparam int DIN_W  = (IN_COUNT  > 1) ? $clog2(IN_COUNT)  : 1;
    localparam int DOUT_W = (OUT_COUNT > 1) ? $clog2(OUT_COUNT) : 1;
    localparam int TOT_W  = (M > 1)         ? $clog2(M)         : 1;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        PAD   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [COM_MUL-1:0]   stage;
    logic [DIN_W-1:0]     din_cnt;
    logic [DOUT_W-1:0]    dout_cnt;
    logic [TOT_W-1:0]     dout_total;

    logic accept;
    logic din_last;
    logic dout_last;
    logic tot_last;

    // Handshake: an input word transfers on a cycle with blob_din_en while
    // blob_din_rdy=1; an output word transfers on blob_dout_en, which is only
    // raised when the consumer shows blob_dout_rdy=1 during DRAIN.
    assign blob_din_rdy  = (state == FILL);
    assign accept        = blob_din_en & blob_din_rdy;
    assign blob_dout     = stage[OUT_WIDTH-1:0];
    assign blob_dout_en  = (state == DRAIN) & blob_dout_rdy;
    assign blob_dout_eop = blob_dout_en & tot_last;

    assign din_last  = (din_cnt    == DIN_W'(IN_COUNT - 1));
    assign dout_last = (dout_cnt   == DOUT_W'(OUT_COUNT - 1));
    assign tot_last  = (dout_total == TOT_W'(M - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            FILL: begin
                if (accept) begin
                    if (din_last) begin
                        state_next = DRAIN;
                    end else if (blob_din_eop) begin
                        state_next = PAD;
                    end
                end
            end
            PAD: begin
                if (din_last) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (blob_dout_en && (dout_last || tot_last)) begin
                    state_next = FILL;
                end
            end
            default: state_next = FILL;
        endcase
    end

    // Leaving DRAIN clears the stage so pad words beyond the blob end are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage      <= '0;
            din_cnt    <= '0;
            dout_cnt   <= '0;
            dout_total <= '0;
        end else begin
            unique case (state)
                FILL: begin
                    if (accept) begin
                        stage   <= {blob_din, stage[COM_MUL-1:IN_WIDTH]};
                        din_cnt <= din_last ? '0 : din_cnt + 1'b1;
                    end
                end
                PAD: begin
                    stage   <= {{IN_WIDTH{1'b0}}, stage[COM_MUL-1:IN_WIDTH]};
                    din_cnt <= din_last ? '0 : din_cnt + 1'b1;
                end
                DRAIN: begin
                    if (blob_dout_en) begin
                        dout_total <= tot_last ? '0 : dout_total + 1'b1;
                        if (dout_last || tot_last) begin
                            dout_cnt <= '0;
                            stage    <= '0;
                        end else begin
                            dout_cnt <= dout_cnt + 1'b1;
                            stage    <= {{OUT_WIDTH{1'b0}}, stage[COM_MUL-1:OUT_WIDTH]};
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_busn2m_pack.sv
// Directed bench for busn2m_pack with 8-bit in / 16-bit out / 32-bit stage,
// using one M=4 and one M=3 instance selected by sel.
module tb_busn2m_pack;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  din;
    logic        din_en;
    logic        din_eop;
    logic        dout_rdy;
    logic        sel;

    logic        rdy4, rdy3, en4, en3, eop4, eop3;
    logic [15:0] dout4, dout3;
    logic        din_rdy, dout_en, dout_eop;
    logic [15:0] dout;

    int n_vec = 0;
    int n_err = 0;

    logic [8:0]  in_q[$];
    logic [16:0] exp_q[$];
    int          stall_runs[$];
    int          acc_cyc[$];
    int          eop_cyc[$];

    always #5 clk = ~clk;

    busn2m_pack #(.IN_WIDTH(8), .OUT_WIDTH(16), .COM_MUL(32), .M(4)) u_dut4 (
        .clk(clk), .rst(rst), .blob_din(din), .blob_din_rdy(rdy4),
        .blob_din_en(din_en & ~sel), .blob_din_eop(din_eop), .blob_dout(dout4),
        .blob_dout_rdy(dout_rdy), .blob_dout_en(en4), .blob_dout_eop(eop4)
    );

    busn2m_pack #(.IN_WIDTH(8), .OUT_WIDTH(16), .COM_MUL(32), .M(3)) u_dut3 (
        .clk(clk), .rst(rst), .blob_din(din), .blob_din_rdy(rdy3),
        .blob_din_en(din_en & sel), .blob_din_eop(din_eop), .blob_dout(dout3),
        .blob_dout_rdy(dout_rdy), .blob_dout_en(en3), .blob_dout_eop(eop3)
    );

    assign din_rdy  = sel ? rdy3  : rdy4;
    assign dout_en  = sel ? en3   : en4;
    assign dout_eop = sel ? eop3  : eop4;
    assign dout     = sel ? dout3 : dout4;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; din_en = 1'b0; din_eop = 1'b0; din = '0; dout_rdy = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_din_rdy", din_rdy, 1);
        check("rst_dout", dout, 0);
        check("rst_dout_en", dout_en, 0);
        check("rst_dout_eop", dout_eop, 0);
        rst = 1'b0;
        in_q.delete(); exp_q.delete(); stall_runs.delete();
        acc_cyc.delete(); eop_cyc.delete();
    endtask

    task automatic push_blob(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            in_q.push_back({(i == n - 1), 8'(first + 8'(i))});
        end
    endtask

    // Clocks the queued input through the DUT and checks every output word.
    task automatic run(input int bp);
        int cyc = 0;
        int stall = 0;
        int idle = 0;
        int bp_left = bp;
        logic bp_now;
        logic [8:0]  w;
        logic [16:0] e;
        while ((in_q.size() > 0 || exp_q.size() > 0 || idle < 3) && cyc < 200) begin
            @(negedge clk);
            din_en = 1'b0; din_eop = 1'b0; din = '0; dout_rdy = 1'b1; bp_now = 1'b0;
            if (din_rdy) begin
                if (stall > 0) stall_runs.push_back(stall);
                stall = 0;
                if (in_q.size() > 0) begin
                    w = in_q.pop_front();
                    {din_eop, din} = w;
                    din_en = 1'b1;
                    acc_cyc.push_back(cyc);
                end
            end else begin
                stall++;
                if (bp_left > 0) begin
                    dout_rdy = 1'b0;
                    bp_left--;
                    bp_now = 1'b1;
                end
            end
            #1;
            if (bp_now) begin
                check("bp_dout", dout, 16'h0201);
                check("bp_dout_en", dout_en, 0);
                check("bp_din_rdy", din_rdy, 0);
            end else if (dout_en) begin
                if (exp_q.size() == 0) begin
                    check("spurious_dout_en", dout_en, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("dout_word", {dout_eop, dout}, e);
                    if (dout_eop) eop_cyc.push_back(cyc);
                end
            end
            if (in_q.size() == 0 && exp_q.size() == 0) idle++;
            cyc++;
        end
        if (cyc >= 200) check("run_timeout", 1, 0);
    endtask

    task automatic exp_full_blob();
        exp_q.push_back({1'b0, 16'h0201});
        exp_q.push_back({1'b0, 16'h0403});
        exp_q.push_back({1'b0, 16'h0605});
        exp_q.push_back({1'b1, 16'h0807});
    endtask

    initial begin
        rst = 1'b1; din = '0; din_en = 1'b0; din_eop = 1'b0; dout_rdy = 1'b1; sel = 1'b0;

        // Full blob, two 2-cycle drain stalls.
        do_reset();
        push_blob(8'h01, 8);
        exp_full_blob();
        run(0);
        check("full_stall_cnt", stall_runs.size(), 2);
        if (stall_runs.size() == 2) begin
            check("full_stall0", stall_runs[0], 2);
            check("full_stall1", stall_runs[1], 2);
        end

        // Backpressure for 5 cycles on the first drain word.
        do_reset();
        push_blob(8'h01, 8);
        exp_full_blob();
        run(5);

        // Reset in the middle of DRAIN, then a clean blob.
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            din_en = 1'b1; din = 8'(i); din_eop = 1'b0;
        end
        @(negedge clk);
        din_en = 1'b0; din = '0;
        #1;
        check("mid_first_dout", dout, 16'h0201);
        check("mid_first_en", dout_en, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("mid_rst_din_rdy", din_rdy, 1);
        check("mid_rst_dout", dout, 0);
        check("mid_rst_dout_en", dout_en, 0);
        rst = 1'b0;
        push_blob(8'h01, 8);
        exp_full_blob();
        run(0);

        // Back-to-back blobs.
        do_reset();
        push_blob(8'h01, 8);
        push_blob(8'h01, 8);
        exp_full_blob();
        exp_full_blob();
        run(0);
        check("b2b_eop_cnt", eop_cyc.size(), 2);
        if (eop_cyc.size() == 2 && acc_cyc.size() == 16) begin
            check("b2b_second_start", acc_cyc[8], eop_cyc[0] + 1);
        end

        // Partial last group with padding and truncation on the M=3 instance.
        sel = 1'b1;
        do_reset();
        push_blob(8'h11, 6);
        exp_q.push_back({1'b0, 16'h1211});
        exp_q.push_back({1'b0, 16'h1413});
        exp_q.push_back({1'b1, 16'h1615});
        run(0);
        check("pad_stall_cnt", stall_runs.size(), 2);
        if (stall_runs.size() == 2) begin
            check("pad_stall0", stall_runs[0], 2);
            check("pad_stall1", stall_runs[1], 3);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
